// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I MEM-stage load/store front end for a word-wide memory without byte enables
// Ports:
//   clk, reset (sync, active-high)
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : request from EX/MEM
//   resp_valid/resp_rdata/resp_misaligned/resp_illegal          : one-cycle completion
//   mem_write/mem_address/mem_write_data/mem_read_data          : word-wide data memory
module mem_access_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = ADDR_WIDTH - 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_misaligned,
  output logic                     resp_illegal,
  output logic                     mem_write,
  output logic [MEM_ADDR_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);
  typedef enum logic [2:0] {IDLE, READ, LOAD_RESP, WRITE, RMW_READ, RMW_MERGE, ERR} state_t;
  state_t state_q, state_d;
  logic [2:0] f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic ill_q, mis_q, ill_in, mis_in;
  logic [4:0] shamt;
  logic [15:0] lane;
  logic [DATA_WIDTH-1:0] lane_mask, mask, ins, load_data;
  always_comb begin
    ill_in = req_write ? (req_funct3[2] | &req_funct3[1:0]) : (&req_funct3[1:0] | &req_funct3[2:1]);
    mis_in = (req_funct3[1:0] == 2'b01 & req_addr[0]) | (req_funct3[1:0] == 2'b10 & |req_addr[1:0]);
    state_d = state_q == IDLE ? (req_valid ? ((ill_in | mis_in) ? ERR :
                                              !req_write ? READ :
                                              req_funct3[1] ? WRITE : RMW_READ) : IDLE) :
              state_q == READ ? LOAD_RESP :
              state_q == RMW_READ ? RMW_MERGE : IDLE;
    // funct3[0] distinguishes half (lane = addr[1]) from byte (lane = addr[1:0])
    shamt = f3_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    lane = 16'(mem_read_data >> shamt);
    load_data = f3_q[1] ? mem_read_data :
                f3_q[0] ? {{16{~f3_q[2] & lane[15]}}, lane} : {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
    lane_mask = f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    mask = lane_mask << shamt;
    ins = (wdata_q & lane_mask) << shamt;
    req_ready = !reset & state_q == IDLE;
    mem_write = !reset & (state_q == WRITE | state_q == RMW_MERGE);
    mem_address = (!reset & state_q inside {READ, RMW_READ, WRITE, RMW_MERGE}) ? addr_q[ADDR_WIDTH-1:2] : '0;
    mem_write_data = reset ? '0 :
                     state_q == WRITE ? wdata_q :
                     state_q == RMW_MERGE ? (mem_read_data & ~mask) | ins : '0;
    resp_valid = !reset & state_q inside {LOAD_RESP, WRITE, RMW_MERGE, ERR};
    resp_rdata = (!reset & state_q == LOAD_RESP) ? load_data : '0;
    resp_illegal = !reset & state_q == ERR & ill_q;
    resp_misaligned = !reset & state_q == ERR & mis_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      ill_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        f3_q <= req_funct3;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        ill_q <= ill_in;
        mis_q <= mis_in & !ill_in;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench against a byte-addressed reference model
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_write;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_write_data, mem_read_data;
  logic resp_valid, resp_misaligned, resp_illegal, mem_write;
  logic [29:0] mem_address;
  logic [31:0] mem_w [64];
  logic [7:0] ref_b [256];
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .resp_illegal(resp_illegal), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );
  always @(posedge clk) begin
    if (mem_write) mem_w[mem_address[5:0]] <= mem_write_data;
    mem_read_data <= mem_w[mem_address[5:0]];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_word(input int wi);
    return {ref_b[wi*4+3], ref_b[wi*4+2], ref_b[wi*4+1], ref_b[wi*4]};
  endfunction
  task automatic preload(input int wi, input logic [31:0] v);
    logic [31:0] t;
    mem_w[wi] = v;
    for (int j = 0; j < 4; j++) begin
      t = v >> (8 * j);
      ref_b[wi*4+j] = t[7:0];
    end
  endtask
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
    int sz, lat, exp_lat, wr_cnt;
    logic ill, mis, ok, got_ill, got_mis;
    logic [31:0] exp_rd, got_rd, wr_data, t;
    logic [29:0] wr_addr;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill = w ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = !ill && (int'(a) % sz != 0);
    ok = !ill && !mis;
    exp_lat = (!ok || (w && sz == 4)) ? 1 : 2;
    exp_rd = '0;
    if (!w && ok) begin
      for (int i = 0; i < sz; i++) exp_rd |= 32'(ref_b[int'(a) + i]) << (8 * i);
      if (!f3[2] && sz < 4 && exp_rd[8*sz-1]) exp_rd |= 32'hFFFF_FFFF << (8 * sz);
    end
    if (w && ok)
      for (int i = 0; i < sz; i++) begin
        t = wd >> (8 * i);
        ref_b[int'(a) + i] = t[7:0];
      end
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = {24'b0, a}; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    check("busy", 32'(req_ready), 32'd0);
    lat = 0; wr_cnt = 0; got_ill = 1'b0; got_mis = 1'b0; got_rd = '0; wr_data = '0; wr_addr = '0;
    for (int c = 1; c <= 4 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_write) begin
        wr_cnt++;
        wr_addr = mem_address;
        wr_data = mem_write_data;
      end
      if (resp_valid) begin
        lat = c;
        got_ill = resp_illegal;
        got_mis = resp_misaligned;
        got_rd = resp_rdata;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("illegal", 32'(got_ill), 32'(ill));
    check("misaligned", 32'(got_mis), 32'(mis));
    check("rdata", got_rd, exp_rd);
    check("wr_count", 32'(wr_cnt), (w && ok) ? 32'd1 : 32'd0);
    if (w && ok) begin
      check("wr_addr", 32'(wr_addr), 32'(a >> 2));
      check("wr_data", wr_data, ref_word(int'(a >> 2)));
      @(negedge clk);
      check("mem_word", mem_w[a >> 2], ref_word(int'(a >> 2)));
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [9:0] pat;
    logic w;
    logic [2:0] f3;
    logic [7:0] a;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(4, 32'h8899_AABB);
    preload(12, 32'h1122_3344);
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_flags", {30'b0, resp_misaligned, resp_illegal}, 32'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_no_resp", 32'(resp_valid), 32'd0);
    do_req(0, 3'd0, 8'h11, 0);
    do_req(0, 3'd4, 8'h11, 0);
    do_req(0, 3'd1, 8'h12, 0);
    do_req(0, 3'd5, 8'h12, 0);
    do_req(1, 3'd2, 8'h20, 32'hDEAD_BEEF);
    do_req(0, 3'd2, 8'h20, 0);
    do_req(1, 3'd0, 8'h31, 32'h0000_0055);
    do_req(1, 3'd1, 8'h32, 32'h0000_CAFE);
    do_req(0, 3'd2, 8'h30, 0);
    do_req(0, 3'd2, 8'h22, 0);
    do_req(1, 3'd5, 8'h20, 32'h1234_5678);
    do_req(0, 3'd1, 8'h13, 0);
    // reset during the merge cycle of an SB must abort the write and the response
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h31; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    check("abort_mem_word", mem_w[12], ref_word(12));
    // back-to-back loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat = {pat[7:0], req_ready, resp_valid};
      if (resp_valid) check("b2b_rdata", resp_rdata, ref_word(8));
    end
    req_valid = 1'b0;
    check("b2b_pattern", 32'(pat), 32'(10'b00_01_10_00_01));
    @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0)
        a[1:0] = (f3[1:0] == 2'd2) ? 2'b00 : f3[0] ? {a[1], 1'b0} : a[1:0];
      do_req(w, f3, a, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
